bullet_pool: RTL and testbench
==============================

// Module: bullet_pool
// PURPOSE
// - Per-player projectile manager: owns NUM_SLOTS bullets, allocates one per accepted fire, advances all
//   by STEP_X once per frame tick, retires bullets on bound exit or external hit.
// - Generalises the single fixed bullet (BULLET_STEP_X) to N slots, either direction, with fire cooldown.
// - Sits between player control (fire request) and renderer/collision (slot positions, hit clears).
// PARAMETERS
// - NUM_SLOTS     4     bullet slots (1..16)
// - X_WIDTH       12    signed x coordinate width
// - Y_WIDTH       11    signed y coordinate width
// - STEP_X        6     x displacement per frame tick (unsigned, >0)
// - DIR_RIGHT     1     1: x += STEP_X per tick; 0: x -= STEP_X
// - X_MIN         -640  lowest legal x (inclusive)
// - X_MAX         639   highest legal x (inclusive)
// - COOLDOWN      8     frame ticks after a fire before next fire allowed (0 = none)
// PORTS
// - i_clk         in   1                    clock; single domain
// - i_rst_n       in   1                    synchronous reset, active-low
// - i_frame_tick  in   1                    one-cycle pulse per video frame
// - i_fire_valid  in   1                    fire request
// - o_fire_ready  out  1                    fire accepted when valid && ready
// - i_fire_x      in   X_WIDTH              spawn x (signed)
// - i_fire_y      in   Y_WIDTH              spawn y (signed)
// - i_hit         in   NUM_SLOTS            per-slot clear (collision detected)
// - o_active      out  NUM_SLOTS            slot occupied
// - o_x           out  NUM_SLOTS*X_WIDTH    slot k x at [k*X_WIDTH +: X_WIDTH]
// - o_y           out  NUM_SLOTS*Y_WIDTH    slot k y at [k*Y_WIDTH +: Y_WIDTH]
// - o_count       out  $clog2(NUM_SLOTS+1)  number of active slots
// BEHAVIOUR
// - Reset (i_rst_n=0 at posedge): o_active=0, all o_x/o_y=0, o_count=0, cooldown=0; o_fire_ready=1 first
//   cycle after reset. Reset mid-flight discards all bullets.
// - Per-slot state: IDLE (active=0) / FLIGHT (active=1). o_count = popcount(o_active), registered.
// - o_fire_ready = (any slot IDLE) && (cooldown==0); combinational from registered state only.
// - Fire accept: lowest-index IDLE slot -> FLIGHT next cycle, x=i_fire_x, y=i_fire_y; cooldown<=COOLDOWN.
// - Frame tick: every FLIGHT slot not accepting a hit computes nx = x +/- STEP_X in X_WIDTH+1 bits;
//   nx > X_MAX (right) or nx < X_MIN (left) -> IDLE (x,y hold last value); else x<=nx. y never changes.
// - Cooldown: decrements by 1 on frame tick, saturates at 0.
// - Simultaneous events, same cycle:
//   - hit + tick on a slot: hit wins, slot IDLE, no move.
//   - hit on IDLE slot: ignored.
//   - fire + tick: new bullet spawns at i_fire_x unadvanced; cooldown loads COOLDOWN (load beats decrement).
//   - fire + hit freeing a slot: freed slot not visible to ready until next cycle.
//   - multiple hits/expiries in one cycle: all applied; o_count reflects all next cycle.
// - Spawn outside [X_MIN,X_MAX]: accepted; bullet expires on its first tick.
// - Latency: fire/hit/tick effects visible on outputs 1 cycle after the sampling edge.
// CONFIGURATION
// - BULLET_POOL_STATS_EN defined: adds o_fired_cnt (16b, accepted fires) and o_expired_cnt (16b,
//   bound exits only, hits not counted); both saturate at 16'hFFFF, reset to 0.
// - Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
// - Reset, fire (x=100,y=50), 3 ticks -> slot0 active, x=118, y=50, o_count=1.
// - 4 fires each after 8 ticks -> slots 0..3 active, o_fire_ready=0 with cooldown=0; hit[2] -> next fire
//   lands in slot 2.
// - Slot at x=636 (DIR_RIGHT=1), tick -> nx=642>639, slot IDLE, o_count drops by 1; stats build:
//   o_expired_cnt=1.
// - i_hit[0]=1 with tick on active slot0 x=200 -> slot0 IDLE, x holds 200.
// - Fire (x=10) with tick same cycle -> x=10, cooldown=8; next tick cooldown=7, x=16; ready after 8 ticks.
// - Reset asserted with 3 bullets in flight -> o_active=0, o_count=0, o_fire_ready=1 next cycle.

Source files
------------

// File: rtl/bullet_pool.sv
// bullet_pool: per-player projectile manager with NUM_SLOTS bullets.
// Each slot is either idle or in flight; accepted fires take the lowest idle
// slot, frame ticks advance every flying bullet by STEP_X, and bullets retire
// on leaving [X_MIN, X_MAX] or on an external hit.
// Optional build macro BULLET_POOL_STATS_EN adds saturating 16-bit counters
// for accepted fires and bound exits.
module bullet_pool #(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned X_WIDTH   = 12,
   parameter int unsigned Y_WIDTH   = 11,
   parameter int unsigned STEP_X    = 6,
   parameter int unsigned DIR_RIGHT = 1,
   parameter int          X_MIN     = -640,
   parameter int          X_MAX     = 639,
   parameter int unsigned COOLDOWN  = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_frame_tick,
   input  logic                               i_fire_valid,
   output logic                               o_fire_ready,
   input  logic [X_WIDTH-1:0]                 i_fire_x,
   input  logic [Y_WIDTH-1:0]                 i_fire_y,
   input  logic [NUM_SLOTS-1:0]               i_hit,
   output logic [NUM_SLOTS-1:0]               o_active,
   output logic [NUM_SLOTS*X_WIDTH-1:0]       o_x,
   output logic [NUM_SLOTS*Y_WIDTH-1:0]       o_y,
   output logic [$clog2(NUM_SLOTS+1)-1:0]     o_count
`ifdef BULLET_POOL_STATS_EN
   ,
   output logic [15:0]                        o_fired_cnt,
   output logic [15:0]                        o_expired_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
   localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic signed [X_WIDTH:0] XMAX_E = (X_WIDTH+1)'(X_MAX);
   localparam logic signed [X_WIDTH:0] XMIN_E = (X_WIDTH+1)'(X_MIN);
   localparam logic signed [X_WIDTH:0] STEP_E = (X_WIDTH+1)'(STEP_X);

   logic [NUM_SLOTS-1:0]              active_q, active_d;
   logic [NUM_SLOTS-1:0][X_WIDTH-1:0] x_q, x_d;
   logic [NUM_SLOTS-1:0][Y_WIDTH-1:0] y_q, y_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [CD_W-1:0]                   cool_q, cool_d;
   logic [CNT_W-1:0]                  exp_num;
   logic signed [X_WIDTH:0]           nx;
   logic [NUM_SLOTS-1:0]              free_c;
   logic [NUM_SLOTS-1:0]              free_sel_c;
   logic                              fire_acc_c;

   // Fire handshake: lowest idle slot, only when cooldown has elapsed.
   assign free_c       = ~active_q;
   assign free_sel_c   = free_c & (active_q + NUM_SLOTS'(1));
   assign o_fire_ready = (|free_c) && (cool_q == '0);
   assign fire_acc_c   = i_fire_valid && o_fire_ready;

   assign o_active = active_q;
   assign o_x      = x_q;
   assign o_y      = y_q;
   assign o_count  = cnt_q;

   // Next-state for slots, occupancy count and cooldown.
   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      cool_d   = cool_q;
      cnt_d    = '0;
      exp_num  = '0;
      nx       = '0;
      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
         if (active_q[k]) begin
            if (i_hit[k]) begin
               active_d[k] = 1'b0;
            end else if (i_frame_tick) begin
               nx = {x_q[k][X_WIDTH-1], x_q[k]};
               nx = (DIR_RIGHT != 0) ? (nx + STEP_E) : (nx - STEP_E);
               if ((nx > XMAX_E) || (nx < XMIN_E)) begin
                  active_d[k] = 1'b0;
                  exp_num     = exp_num + CNT_W'(1);
               end else begin
                  x_d[k] = nx[X_WIDTH-1:0];
               end
            end
         end else if (fire_acc_c && free_sel_c[k]) begin
            active_d[k] = 1'b1;
            x_d[k]      = i_fire_x;
            y_d[k]      = i_fire_y;
         end
      end
      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
         cnt_d = cnt_d + CNT_W'(active_d[k]);
      end
      if (fire_acc_c) begin
         cool_d = CD_W'(COOLDOWN);
      end else if (i_frame_tick && (cool_q != '0)) begin
         cool_d = cool_q - CD_W'(1);
      end
   end

   // Slot, count and cooldown registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         active_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         cnt_q    <= '0;
         cool_q   <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         cool_q   <= cool_d;
      end
   end

`ifdef BULLET_POOL_STATS_EN
   logic [15:0] fired_q, fired_d;
   logic [15:0] expired_q, expired_d;
   logic [16:0] exp_sum;

   // Saturating statistics: accepted fires and bound exits.
   always_comb begin
      fired_d = fired_q;
      if (fire_acc_c && (fired_q != 16'hFFFF)) begin
         fired_d = fired_q + 16'd1;
      end
      exp_sum   = 17'(expired_q) + 17'(exp_num);
      expired_d = exp_sum[16] ? 16'hFFFF : exp_sum[15:0];
   end

   // Statistics registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fired_q   <= '0;
         expired_q <= '0;
      end else begin
         fired_q   <= fired_d;
         expired_q <= expired_d;
      end
   end

   assign o_fired_cnt   = fired_q;
   assign o_expired_cnt = expired_q;
`else
   logic unused_exp_num;
   assign unused_exp_num = ^exp_num;
`endif

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus a randomized
// run compared against an integer-arithmetic model of the slot pool.
module tb_bullet_pool;

   localparam int NS   = 4;
   localparam int XW   = 12;
   localparam int YW   = 11;
   localparam int STEP = 6;
   localparam int XMIN = -640;
   localparam int XMAX = 639;
   localparam int CD   = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                frame_tick;
   logic                fire_valid;
   logic                fire_ready;
   logic [XW-1:0]       fire_x;
   logic [YW-1:0]       fire_y;
   logic [NS-1:0]       hit;
   logic [NS-1:0]       active;
   logic [NS*XW-1:0]    xs;
   logic [NS*YW-1:0]    ys;
   logic [2:0]          count;
`ifdef BULLET_POOL_STATS_EN
   logic [15:0]         fired_cnt;
   logic [15:0]         expired_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit ma[NS];
   int mx[NS];
   int my[NS];
   int mcool;
   int mfired;
   int mexp;

   always #5 clk = ~clk;

   bullet_pool dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_frame_tick (frame_tick),
      .i_fire_valid (fire_valid),
      .o_fire_ready (fire_ready),
      .i_fire_x     (fire_x),
      .i_fire_y     (fire_y),
      .i_hit        (hit),
      .o_active     (active),
      .o_x          (xs),
      .o_y          (ys),
      .o_count      (count)
`ifdef BULLET_POOL_STATS_EN
      ,
      .o_fired_cnt  (fired_cnt),
      .o_expired_cnt(expired_cnt)
`endif
   );

   function automatic int gx(int k);
      logic signed [XW-1:0] v;
      v = xs[k*XW +: XW];
      return int'(v);
   endfunction

   function automatic int gy(int k);
      logic signed [YW-1:0] v;
      v = ys[k*YW +: YW];
      return int'(v);
   endfunction

   function automatic int mcount();
      int c = 0;
      for (int k = 0; k < NS; k++) c += int'(ma[k]);
      return c;
   endfunction

   function automatic bit mready();
      bit any_idle = 0;
      for (int k = 0; k < NS; k++) if (!ma[k]) any_idle = 1;
      return any_idle && (mcool == 0);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NS; k++) begin
         ma[k] = 0; mx[k] = 0; my[k] = 0;
      end
      mcool = 0; mfired = 0; mexp = 0;
   endtask

   // Apply one cycle of the pool's rules to the model, from pre-edge state.
   task automatic model_step(bit fire, int fx, int fy, logic [NS-1:0] h, bit tick);
      int  sel = -1;
      bit  rdy;
      int  nx;
      for (int k = NS - 1; k >= 0; k--) if (!ma[k]) sel = k;
      rdy = mready();
      for (int k = 0; k < NS; k++) begin
         if (ma[k]) begin
            if (h[k]) begin
               ma[k] = 0;
            end else if (tick) begin
               nx = mx[k] + STEP;
               if (nx > XMAX || nx < XMIN) begin
                  ma[k] = 0;
                  mexp++;
               end else begin
                  mx[k] = nx;
               end
            end
         end
      end
      if (fire && rdy) begin
         ma[sel] = 1; mx[sel] = fx; my[sel] = fy;
         mcool = CD;
         mfired++;
      end else if (tick && mcool > 0) begin
         mcool--;
      end
   endtask

   task automatic drive(bit fire, int fx, int fy, logic [NS-1:0] h, bit tick);
      fire_valid = fire;
      fire_x     = XW'(fx);
      fire_y     = YW'(fy);
      hit        = h;
      frame_tick = tick;
      model_step(fire, fx, fy, h, tick);
      @(posedge clk);
      #1;
      fire_valid = 0; hit = '0; frame_tick = 0;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 1);
   endtask

   task automatic do_reset();
      rst_n = 0; fire_valid = 0; hit = '0; frame_tick = 0; fire_x = '0; fire_y = '0;
      @(posedge clk);
      #1;
      rst_n = 1;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (active !== 4'b0000) begin n_bad++; $display("FAIL reset_active got %b exp 0000", active); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
      n_cmp++; if (fire_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", fire_ready); end
      n_cmp++; if (xs !== '0 || ys !== '0) begin n_bad++; $display("FAIL reset_xy got %h/%h exp 0/0", xs, ys); end
   endtask

   task automatic test_basic_flight();
      do_reset();
      drive(1, 100, 50, '0, 0);
      ticks(3);
      n_cmp++; if (active !== 4'b0001) begin n_bad++; $display("FAIL basic_active got %b exp 0001", active); end
      n_cmp++; if (gx(0) !== 118) begin n_bad++; $display("FAIL basic_x got %0d exp 118", gx(0)); end
      n_cmp++; if (gy(0) !== 50) begin n_bad++; $display("FAIL basic_y got %0d exp 50", gy(0)); end
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL basic_count got %0d exp 1", count); end
   endtask

   task automatic test_fill_and_hit();
      do_reset();
      for (int f = 0; f < NS; f++) begin
         drive(1, 0, f * 10, '0, 0);
         ticks(8);
      end
      n_cmp++; if (active !== 4'b1111) begin n_bad++; $display("FAIL fill_active got %b exp 1111", active); end
      n_cmp++; if (fire_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready got %b exp 0", fire_ready); end
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count got %0d exp 4", count); end
      drive(1, 55, 0, 4'b0100, 0);
      n_cmp++; if (active !== 4'b1011) begin n_bad++; $display("FAIL hit_fire_same_cycle got %b exp 1011", active); end
      n_cmp++; if (count !== 3'd3 || fire_ready !== 1'b1) begin n_bad++; $display("FAIL hit_count_ready got %0d/%b exp 3/1", count, fire_ready); end
      drive(1, -100, -20, '0, 0);
      n_cmp++; if (active !== 4'b1111 || gx(2) !== -100 || gy(2) !== -20) begin
         n_bad++; $display("FAIL refill_slot2 got %b x=%0d y=%0d exp 1111 x=-100 y=-20", active, gx(2), gy(2));
      end
   endtask

   task automatic test_expire();
      do_reset();
      drive(1, 633, 7, '0, 0);
      ticks(1);
      n_cmp++; if (active !== 4'b0001 || gx(0) !== 639) begin n_bad++; $display("FAIL edge_inclusive got %b x=%0d exp 0001 x=639", active, gx(0)); end
      ticks(1);
      n_cmp++; if (active !== 4'b0000 || gx(0) !== 639 || count !== 3'd0) begin
         n_bad++; $display("FAIL edge_exit got %b x=%0d c=%0d exp 0000 x=639 c=0", active, gx(0), count);
      end
      ticks(6);
      drive(1, 636, 3, '0, 0);
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL spawn636_count got %0d exp 1", count); end
      ticks(1);
      n_cmp++; if (active !== 4'b0000 || gx(0) !== 636 || count !== 3'd0) begin
         n_bad++; $display("FAIL exit636 got %b x=%0d c=%0d exp 0000 x=636 c=0", active, gx(0), count);
      end
`ifdef BULLET_POOL_STATS_EN
      n_cmp++; if (expired_cnt !== 16'd2) begin n_bad++; $display("FAIL stats_expired got %0d exp 2", expired_cnt); end
`endif
   endtask

   task automatic test_hit_vs_tick();
      do_reset();
      drive(1, 200, -30, '0, 0);
      drive(0, 0, 0, 4'b0011, 1);
      n_cmp++; if (active !== 4'b0000 || count !== 3'd0) begin n_bad++; $display("FAIL hitwins_active got %b c=%0d exp 0000 c=0", active, count); end
      n_cmp++; if (gx(0) !== 200 || gy(0) !== -30) begin n_bad++; $display("FAIL hitwins_hold got %0d/%0d exp 200/-30", gx(0), gy(0)); end
`ifdef BULLET_POOL_STATS_EN
      n_cmp++; if (expired_cnt !== 16'd0 || fired_cnt !== 16'd1) begin
         n_bad++; $display("FAIL stats_hit got e=%0d f=%0d exp 0/1", expired_cnt, fired_cnt);
      end
`endif
   endtask

   task automatic test_fire_with_tick();
      do_reset();
      drive(1, 10, 5, '0, 1);
      n_cmp++; if (active !== 4'b0001 || gx(0) !== 10 || fire_ready !== 1'b0) begin
         n_bad++; $display("FAIL firetick_spawn got %b x=%0d r=%b exp 0001 x=10 r=0", active, gx(0), fire_ready);
      end
      ticks(1);
      n_cmp++; if (gx(0) !== 16) begin n_bad++; $display("FAIL firetick_step got %0d exp 16", gx(0)); end
      ticks(6);
      n_cmp++; if (fire_ready !== 1'b0) begin n_bad++; $display("FAIL cooldown_7 got %b exp 0", fire_ready); end
      ticks(1);
      n_cmp++; if (fire_ready !== 1'b1 || gx(0) !== 58) begin n_bad++; $display("FAIL cooldown_8 got r=%b x=%0d exp 1 x=58", fire_ready, gx(0)); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      for (int f = 0; f < 3; f++) begin
         drive(1, -600, f, '0, 0);
         ticks(8);
      end
      n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL midflight_pre got %0d exp 3", count); end
      drive(1, 0, 0, '0, 0);
      rst_n = 0; fire_valid = 1; frame_tick = 1;
      @(posedge clk);
      #1;
      n_cmp++; if (active !== 4'b0000 || count !== 3'd0 || fire_ready !== 1'b1) begin
         n_bad++; $display("FAIL midflight_reset got %b c=%0d r=%b exp 0000 0 1", active, count, fire_ready);
      end
      rst_n = 1; fire_valid = 0; frame_tick = 0;
      model_clear();
   endtask

   task automatic test_random();
      int fx, fy;
      bit fire, tick;
      logic [NS-1:0] h;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         fire = ($urandom_range(0, 1) == 1);
         tick = ($urandom_range(0, 2) == 0);
         h    = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
         fx   = int'($urandom_range(0, 1500)) - 750;
         fy   = int'($urandom_range(0, 1000)) - 500;
         drive(fire, fx, fy, h, tick);
         for (int k = 0; k < NS; k++) begin
            n_cmp++;
            if (active[k] !== ma[k] || gx(k) !== mx[k] || gy(k) !== my[k]) begin
               n_bad++;
               $display("FAIL rand_slot%0d cyc %0d got a=%b x=%0d y=%0d exp a=%b x=%0d y=%0d",
                        k, c, active[k], gx(k), gy(k), ma[k], mx[k], my[k]);
            end
         end
         n_cmp++;
         if (int'(count) !== mcount() || fire_ready !== mready()) begin
            n_bad++;
            $display("FAIL rand_count_ready cyc %0d got c=%0d r=%b exp c=%0d r=%b", c, count, fire_ready, mcount(), mready());
         end
`ifdef BULLET_POOL_STATS_EN
         n_cmp++;
         if (int'(fired_cnt) !== mfired || int'(expired_cnt) !== mexp) begin
            n_bad++;
            $display("FAIL rand_stats cyc %0d got f=%0d e=%0d exp f=%0d e=%0d", c, fired_cnt, expired_cnt, mfired, mexp);
         end
`endif
      end
   endtask

   initial begin
      rst_n = 0; fire_valid = 0; frame_tick = 0; hit = '0; fire_x = '0; fire_y = '0;
      model_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_basic_flight();
      test_fill_and_hit();
      test_expire();
      test_hit_vs_tick();
      test_fire_with_tick();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
